// File: rtl/sig_logger_pkg.sv
// Shared types and parameter defaults for the signal change logger.
package sig_logger_pkg;

  localparam int NCH_DEF   = 3;
  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Event record at the default widths. The top re-declares the same
  // field order at its own widths when the parameters are overridden.
  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic [NCH_DEF-1:0]  val;
    logic [NCH_DEF-1:0]  chg;
    logic                drop;
  } sig_event_t;

endpackage

// File: rtl/sig_logger_fifo.sv
// Synchronous DEPTH-entry event FIFO. A push into a full FIFO is accepted
// only when a pop happens on the same edge; a pop of an empty FIFO is ignored.
module sig_logger_fifo
  import sig_logger_pkg::*;
#(
  parameter type T     = sig_event_t,
  parameter int  DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Advance read and write pointers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Write the storage array.
  // NOTE: the array has no reset; entries are only observable once written,
  // and the consumer masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sig_change_logger.sv
// Logs changes on NCH synchronous signals as timestamped events into a FIFO,
// with drop accounting when the consumer falls behind.
module sig_change_logger
  import sig_logger_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NCH-1:0]  sig_in,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [TS_W-1:0] ev_ts,
  output logic [NCH-1:0]  ev_val,
  output logic [NCH-1:0]  ev_chg,
  output logic            ev_drop,
  output logic            overflow,
  output logic [7:0]      drop_cnt
);

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [NCH-1:0]  val;
    logic [NCH-1:0]  chg;
    logic            drop;
  } ev_t;

  state_t          state;
  state_t          state_nxt;
  logic [TS_W-1:0] ts;
  logic [NCH-1:0]  prev;
  logic [NCH-1:0]  chg;
  logic            pending_drop;
  logic            push_req;
  ev_t             push_ev;
  ev_t             head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            accept;
  logic            drop;

  // Next-state logic for the IDLE/PRIME/RUN controller.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_PRIME;
      ST_PRIME: state_nxt = en ? ST_RUN : ST_IDLE;
      ST_RUN:   if (!en) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Build the candidate event: a full snapshot in PRIME, changes in RUN.
  always_comb begin
    chg          = sig_in ^ prev;
    push_req     = 1'b0;
    push_ev      = '0;
    push_ev.ts   = ts;
    push_ev.val  = sig_in;
    push_ev.drop = pending_drop;
    case (state)
      ST_PRIME: begin
        push_req    = en;
        push_ev.chg = '1;
      end
      ST_RUN: begin
        push_req    = en && (chg != '0);
        push_ev.chg = chg;
      end
      default: ;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop    = !fifo_empty && ev_ready;
  assign accept = push_req && (!fifo_full || pop);
  assign drop   = push_req && fifo_full && !pop;

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Timestamp restarts on entry to PRIME and free-runs while logging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else if (state == ST_IDLE) begin
      if (state_nxt == ST_PRIME) ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  // Previous-sample register for change detection; frozen in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  prev <= '0;
    else if (state != ST_IDLE)   prev <= sig_in;
  end

  // Drop bookkeeping: pending flag for the next accepted event, sticky
  // overflow and a saturating count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_drop <= 1'b0;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
    end else if (drop) begin
      pending_drop <= 1'b1;
      overflow     <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (accept) begin
      pending_drop <= 1'b0;
    end
  end

  sig_logger_fifo #(
    .T     (ev_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (push_ev),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields read as zero while nothing is queued.
  assign ev_valid = !fifo_empty;
  assign ev_ts    = fifo_empty ? '0 : head.ts;
  assign ev_val   = fifo_empty ? '0 : head.val;
  assign ev_chg   = fifo_empty ? '0 : head.chg;
  assign ev_drop  = fifo_empty ? 1'b0 : head.drop;

endmodule

// File: tb/tb_sig_change_logger.sv
// Self-checking bench for sig_change_logger (NCH=3, TS_W=4, DEPTH=8):
// queue-based reference model compared every cycle, plus directed literals.
module tb_sig_change_logger;

  localparam int NCH   = 3;
  localparam int TS_W  = 4;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [NCH-1:0]  sig_in = '0;
  logic            ev_ready = 1'b0;
  logic            ev_valid;
  logic [TS_W-1:0] ev_ts;
  logic [NCH-1:0]  ev_val;
  logic [NCH-1:0]  ev_chg;
  logic            ev_drop;
  logic            overflow;
  logic [7:0]      drop_cnt;

  int checks   = 0;
  int failures = 0;

  sig_change_logger #(
    .NCH   (NCH),
    .TS_W  (TS_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sig_in   (sig_in),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_ts    (ev_ts),
    .ev_val   (ev_val),
    .ev_chg   (ev_chg),
    .ev_drop  (ev_drop),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int ts;
    int val;
    int chg;
    int drop;
  } mev_t;

  mev_t           q[$];
  int             phase = -1;   // cycles since priming, -1 when not logging
  logic [NCH-1:0] last = '0;
  bit             pend = 0;
  bit             ovf = 0;
  int             dcnt = 0;

  always @(posedge clk or negedge rst_n) begin
    bit             pop_m;
    bit             gen;
    mev_t           e;
    logic [NCH-1:0] c;
    if (!rst_n) begin
      q.delete();
      phase = -1;
      last  = '0;
      pend  = 0;
      ovf   = 0;
      dcnt  = 0;
    end else begin
      pop_m = (q.size() > 0) && ev_ready;
      gen   = 0;
      e     = '{0, 0, 0, 0};
      if (phase < 0) begin
        if (en) phase = 0;
      end else begin
        c     = (phase == 0) ? 3'b111 : (sig_in ^ last);
        gen   = en && (c != 0);
        e     = '{phase % 16, int'(sig_in), int'(c), int'(pend)};
        last  = sig_in;
        phase = en ? phase + 1 : -1;
      end
      if (pop_m) void'(q.pop_front());
      if (gen) begin
        if (q.size() < DEPTH) begin
          q.push_back(e);
          pend = 0;
        end else begin
          pend = 1;
          ovf  = 1;
          if (dcnt < 255) dcnt++;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the clock edge.
  always @(posedge clk) begin
    mev_t h;
    #1;
    if (q.size() > 0) begin
      h = q[0];
      check("cmp_valid", 32'(ev_valid), 32'd1);
      check("cmp_ts",    32'(ev_ts),    32'(h.ts));
      check("cmp_val",   32'(ev_val),   32'(h.val));
      check("cmp_chg",   32'(ev_chg),   32'(h.chg));
      check("cmp_drop",  32'(ev_drop),  32'(h.drop));
    end else begin
      check("cmp_valid", 32'(ev_valid), 32'd0);
      check("cmp_zero",  {ev_ts, ev_val, ev_chg, ev_drop}, 32'd0);
    end
    check("cmp_overflow", 32'(overflow), 32'(ovf));
    check("cmp_drop_cnt", 32'(drop_cnt), 32'(dcnt));
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    en       = 1'b0;
    ev_ready = 1'b0;
    sig_in   = '0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    step(2);
    check("reset_valid",    32'(ev_valid), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;

    // Priming snapshot
    en = 1'b1; sig_in = 3'b100;
    step(2);
    check("prime_valid", 32'(ev_valid), 32'd1);
    check("prime_ts",    32'(ev_ts),    32'd0);
    check("prime_val",   32'(ev_val),   32'h4);
    check("prime_chg",   32'(ev_chg),   32'h7);
    check("prime_drop",  32'(ev_drop),  32'd0);
    step(3);
    check("hold_valid", 32'(ev_valid), 32'd1);
    check("hold_ts",    32'(ev_ts),    32'd0);
    ev_ready = 1'b1;
    step(1);
    check("popped_valid", 32'(ev_valid), 32'd0);
    step(3);
    check("quiet_valid", 32'(ev_valid), 32'd0);

    // Single and merged changes
    do_reset();
    en = 1'b1; ev_ready = 1'b1; sig_in = 3'b000;
    step(3);
    sig_in = 3'b001;
    step(1);
    check("chg1_ts",  32'(ev_ts),  32'd2);
    check("chg1_chg", 32'(ev_chg), 32'h1);
    check("chg1_val", 32'(ev_val), 32'h1);
    step(2);
    check("chg_gap_valid", 32'(ev_valid), 32'd0);
    sig_in = 3'b111;
    step(1);
    check("chg2_ts",  32'(ev_ts),  32'd5);
    check("chg2_chg", 32'(ev_chg), 32'h6);
    check("chg2_val", 32'(ev_val), 32'h7);
    step(5);
    check("chg_tail_valid", 32'(ev_valid), 32'd0);

    // Overflow with a stalled consumer
    do_reset();
    en = 1'b1; ev_ready = 1'b0; sig_in = '0;
    step(2);
    repeat (10) begin
      sig_in ^= 3'b001;
      step(1);
    end
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
    check("ovf_flag",     32'(overflow), 32'd1);
    check("ovf_head_ts",  32'(ev_ts),    32'd0);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    sig_in ^= 3'b001;
    step(1);
    ev_ready = 1'b1;
    step(7);
    ev_ready = 1'b0;
    check("after_drop_ts",   32'(ev_ts),   32'd12);
    check("after_drop_flag", 32'(ev_drop), 32'd1);
    check("after_drop_chg",  32'(ev_chg),  32'h1);

    // Full FIFO with a simultaneous pop accepts the push
    repeat (7) begin
      sig_in ^= 3'b010;
      step(1);
    end
    check("full_drop_cnt", 32'(drop_cnt), 32'd3);
    ev_ready = 1'b1;
    sig_in ^= 3'b010;
    step(1);
    ev_ready = 1'b0;
    check("full_pop_push_cnt", 32'(drop_cnt), 32'd3);
    sig_in ^= 3'b010;
    step(1);
    check("full_confirm_cnt", 32'(drop_cnt), 32'd4);

    // Asynchronous reset with events queued
    ev_ready = 1'b1;
    step(4);
    ev_ready = 1'b0;
    check("rst_pre_valid", 32'(ev_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("rst_async_valid",    32'(ev_valid), 32'd0);
    check("rst_async_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_async_overflow", 32'(overflow), 32'd0);
    check("rst_async_ts",       32'(ev_ts),    32'd0);
    step(1);
    rst_n = 1'b1;
    repeat (4) begin
      sig_in ^= 3'b100;
      step(1);
      check("idle_no_event", 32'(ev_valid), 32'd0);
    end
    en = 1'b1;
    step(1);
    check("reprime_wait", 32'(ev_valid), 32'd0);
    step(1);
    check("reprime_valid", 32'(ev_valid), 32'd1);
    check("reprime_ts",    32'(ev_ts),    32'd0);
    check("reprime_chg",   32'(ev_chg),   32'h7);

    // Timestamp wrap at TS_W=4
    do_reset();
    en = 1'b1; ev_ready = 1'b1; sig_in = '0;
    step(2);
    step(16);
    sig_in = 3'b001;
    step(1);
    ev_ready = 1'b0;
    check("wrap_valid", 32'(ev_valid), 32'd1);
    check("wrap_ts",    32'(ev_ts),    32'd1);
    check("wrap_chg",   32'(ev_chg),   32'h1);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sig_change_logger.md
SIG_CHANGE_LOGGER -- requirements
Module: sig_change_logger

Interface
REQ-001 SHALL have parameter NCH, default 3, which is the number of monitored signals.
REQ-002 SHALL have parameter TS_W, default 16, which is the timestamp width.
REQ-003 SHALL have parameter DEPTH, default 8, which is the event FIFO depth (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  logging enable.
REQ-007 SHALL have port sig_in  input  NCH  monitored signals, synchronous to clk.
REQ-008 SHALL have port ev_valid  output  1  head event available.
REQ-009 SHALL have port ev_ready  input  1  consumer accepts head event.
REQ-010 SHALL have port ev_ts  output  TS_W  head event timestamp.
REQ-011 SHALL have port ev_val  output  NCH  sig_in snapshot at event.
REQ-012 SHALL have port ev_chg  output  NCH  changed-bit mask.
REQ-013 SHALL have port ev_drop  output  1  events were lost immediately before this one.
REQ-014 SHALL have port overflow  output  1  sticky drop flag.
REQ-015 SHALL have port drop_cnt  output  8  saturating dropped-event count.

Function
REQ-016 SHALL implement FSM IDLE/PRIME/RUN: IDLE->PRIME when en=1; PRIME->RUN after exactly one cycle; RUN->IDLE when en=0; PRIME->IDLE when en=0.
REQ-017 SHALL run timestamp counter ts from 0 on entering PRIME, +1 per cycle in PRIME/RUN, wrap modulo 2^TS_W, and hold in IDLE.
REQ-018 SHALL, in PRIME, push one event {ts=0, val=sig_in, chg=all ones, drop=pending_drop} and load prev=sig_in.
REQ-019 SHALL, each RUN cycle, compute chg=sig_in XOR prev; when nonzero push one event {ts, sig_in, chg, pending_drop}; prev updated every cycle.
REQ-020 SHALL merge simultaneous changes on several bits into one event; at most one event per cycle.
REQ-021 SHALL have 1-cycle latency: an event pushed at edge k drives ev_valid=1 after edge k when the FIFO was empty.
REQ-022 SHALL emit FIFO order strictly first-in first-out; pop on edge with ev_valid&&ev_ready; ev_* held stable while ev_valid&&!ev_ready.
REQ-023 SHALL, on full with no pop in the same cycle, drop the new event, set overflow, increment drop_cnt saturating at 255, and set pending_drop.
REQ-024 SHALL, on full with pop in the same cycle, accept the push (no drop).
REQ-025 SHALL carry ev_drop=1 on the first accepted event after drops; pending_drop cleared on that push.
REQ-026 SHALL drive ev_valid=0 and ev_ts/ev_val/ev_chg/ev_drop=0 when empty.
REQ-027 SHALL, while en=0, generate no events, continue draining the FIFO, and retain overflow/drop_cnt; sig_in changes in IDLE are not logged; re-enable re-primes.

Reset
REQ-028 SHALL, while rst_n=0 (asynchronously), set state IDLE, FIFO empty, ts=0, prev=0, pending_drop=0, overflow=0, drop_cnt=0, and all outputs 0.
REQ-029 SHALL, on reset mid-operation, discard queued events; no event until en is sampled high after rst_n release.
REQ-030 SHALL clear overflow and drop_cnt only by reset.

Structure
REQ-031 SHALL place state enum, event struct {ts, val, chg, drop}, and parameter defaults in package sig_logger_pkg.
REQ-032 SHALL instantiate sub-module sig_logger_fifo: synchronous DEPTH-entry event FIFO with push/pop/full/empty; FSM, change detect, and drop accounting stay in the top.

Verification
REQ-033 SHALL test release reset, en=1, sig_in=3'b100 -> single event ts=0 val=100 chg=111 drop=0.
REQ-034 SHALL test ev_ready=1, bit0 toggles at ts=2, bits1+2 toggle at ts=5 -> events (ts=2, chg=001) then (ts=5, chg=110), nothing else.
REQ-035 SHALL test DEPTH=8, ev_ready=0, prime plus 10 changes -> 8 queued, drop_cnt=3, overflow=1; pop one, next change event has ev_drop=1.
REQ-036 SHALL test FIFO full, ev_ready=1, and a change in the same cycle -> push accepted, drop_cnt unchanged.
REQ-037 SHALL test TS_W=4, change 17 cycles after prime -> ev_ts=1 (wrap).
REQ-038 SHALL test rst_n low with 4 events queued -> ev_valid=0 immediately, drop_cnt=0, no event after release until en re-sampled.
